// File: rtl/jtag_dbg_pkg.sv
// jtag_dbg_pkg
// Shared constants for the JTAGG debug command controller: command opcodes
// carried in the top two bits of ER1, bit positions of the status word that
// is read back through ER1/ER2 capture, the FSM state type, and the ECP5
// instruction codes host scripts load to reach ER1/ER2.
package jtag_dbg_pkg;

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   localparam int ST_BUSY    = 0;
   localparam int ST_DONE    = 1;
   localparam int ST_ERR     = 2;
   localparam int ST_TIMEOUT = 3;
   localparam int ST_OVERRUN = 4;
   localparam int ST_W       = 5;

   // IR values that select ER1 (command) and ER2 (read-back) on the ECP5 TAP
   localparam logic [7:0] IR_ER1 = 8'h32;
   localparam logic [7:0] IR_ER2 = 8'h38;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } state_t;

endpackage

// File: rtl/jtag_user_dr.sv
// jtag_user_dr
// One JTAGG user data register. While selected it either loads a parallel
// capture value (Capture-DR) or shifts right with tdi entering the MSB
// (Shift-DR), so the LSB is the first bit presented on tdo.
// Ports:
//   jtck, jrstn    clock, asynchronous active-low reset
//   ce             this register is selected by the TAP
//   shift          TAP is in Shift-DR (otherwise a ce cycle is a capture)
//   tdi            serial input
//   capture_value  parallel value loaded on capture
//   value          current register contents
//   tdo            serial output (value[0])
module jtag_user_dr #(
   parameter int WIDTH = 8
) (
   input  logic             jtck,
   input  logic             jrstn,
   input  logic             ce,
   input  logic             shift,
   input  logic             tdi,
   input  logic [WIDTH-1:0] capture_value,
   output logic [WIDTH-1:0] value,
   output logic             tdo
);

   always_ff @(posedge jtck or negedge jrstn) begin
      if (!jrstn) begin
         value <= '0;
      end else if (ce) begin
         if (shift) begin
            value <= {tdi, value[WIDTH-1:1]};
         end else begin
            value <= capture_value;
         end
      end
   end

   assign tdo = value[0];

endmodule

// File: rtl/jtag_dbg_cmd_ctrl.sv
// jtag_dbg_cmd_ctrl
// Debug command controller behind the ECP5 JTAGG ER1/ER2 pair. ER1 carries
// {op, addr, data}; an Update-DR while ER1 is the selected register issues
// the command. WRITE/READ run one req/ack bus transaction with a timeout;
// ER2 reads back {rdata, status}. Everything runs on jtck.
// Ports:
//   jtck, jrstn                 TAP clock, asynchronous active-low reset
//   jtdi, jshift, jupdate       TAP serial data and state indications
//   jce1, jce2                  ER1 / ER2 selected
//   jtdo1, jtdo2                ER1 / ER2 serial outputs
//   bus_req, bus_we             request and direction (1 = write)
//   bus_addr, bus_wdata         held stable for the whole request
//   bus_ack, bus_err, bus_rdata one-cycle completion with error and data
module jtag_dbg_cmd_ctrl
   import jtag_dbg_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic              jtck,
   input  logic              jrstn,
   input  logic              jtdi,
   input  logic              jshift,
   input  logic              jupdate,
   input  logic              jce1,
   input  logic              jce2,
   output logic              jtdo1,
   output logic              jtdo2,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic              bus_err,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam int SR1_W = 2 + ADDR_W + DATA_W;
   localparam int SR2_W = DATA_W + ST_W;
   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

   state_t            state;
   state_t            next_state;
   logic              sel_er1;
   logic              done;
   logic              err;
   logic              timeout;
   logic              overrun;
   logic [DATA_W-1:0] rdata;
   logic [CNT_W-1:0]  count;
   logic [ST_W-1:0]   status;
   logic [SR1_W-1:0]  sr1;
   logic [SR2_W-1:0]  sr2;
   logic [1:0]        cmd_op;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_data;
   logic              cmd_valid;
   logic              cmd_xfer;
   logic              accept;
   logic              reject;
   logic              clear;
   logic              finish_ack;
   logic              finish_to;
   logic              unused_sr2;

   assign cmd_data = sr1[DATA_W-1:0];
   assign cmd_addr = sr1[DATA_W +: ADDR_W];
   assign cmd_op   = sr1[SR1_W-1 -: 2];
   assign cmd_xfer = (cmd_op == OP_WRITE) || (cmd_op == OP_READ);

   // busy is derived from the state so it can never disagree with bus_req
   always_comb begin
      status              = '0;
      status[ST_BUSY]     = (state == S_REQ);
      status[ST_DONE]     = done;
      status[ST_ERR]      = err;
      status[ST_TIMEOUT]  = timeout;
      status[ST_OVERRUN]  = overrun;
   end

   jtag_user_dr #(.WIDTH(SR1_W)) u_er1 (
      .jtck          (jtck),
      .jrstn         (jrstn),
      .ce            (jce1),
      .shift         (jshift),
      .tdi           (jtdi),
      .capture_value ({{(SR1_W-ST_W){1'b0}}, status}),
      .value         (sr1),
      .tdo           (jtdo1)
   );

   jtag_user_dr #(.WIDTH(SR2_W)) u_er2 (
      .jtck          (jtck),
      .jrstn         (jrstn),
      .ce            (jce2),
      .shift         (jshift),
      .tdi           (jtdi),
      .capture_value ({rdata, status}),
      .value         (sr2),
      .tdo           (jtdo2)
   );

   // ER2 contents only leave the chip serially through jtdo2
   assign unused_sr2 = ^sr2;

   // Command decode and transaction sequencing. A command arriving in the
   // same cycle as the ack still sees REQ, so it is rejected as an overrun.
   // Ack is checked before the timeout so a last-cycle ack is a success.
   always_comb begin
      next_state = state;
      cmd_valid  = jupdate && sel_er1;
      accept     = 1'b0;
      reject     = 1'b0;
      clear      = cmd_valid && (cmd_op == OP_CLEAR);
      finish_ack = 1'b0;
      finish_to  = 1'b0;
      case (state)
         S_IDLE: begin
            if (cmd_valid && cmd_xfer) begin
               accept     = 1'b1;
               next_state = S_REQ;
            end
         end
         S_REQ: begin
            reject = cmd_valid && cmd_xfer;
            if (bus_ack) begin
               finish_ack = 1'b1;
               next_state = S_IDLE;
            end else if (count == CNT_MAX) begin
               finish_to  = 1'b1;
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge jtck or negedge jrstn) begin
      if (!jrstn) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Bus request follows the state register directly so that an asynchronous
   // reset removes it without waiting for a clock edge
   assign bus_req = (state == S_REQ);

   // Selection tracking, latched command, timeout counter and sticky status.
   // Completion is applied after CLEAR so a coincident finish is not lost.
   always_ff @(posedge jtck or negedge jrstn) begin
      if (!jrstn) begin
         sel_er1   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         count     <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         timeout   <= 1'b0;
         overrun   <= 1'b0;
         rdata     <= '0;
      end else begin
         if (jce1) begin
            sel_er1 <= 1'b1;
         end else if (jce2) begin
            sel_er1 <= 1'b0;
         end

         if (accept) begin
            bus_we    <= (cmd_op == OP_WRITE);
            bus_addr  <= cmd_addr;
            bus_wdata <= cmd_data;
            count     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            timeout   <= 1'b0;
         end else if ((state == S_REQ) && !finish_ack && !finish_to) begin
            count <= count + 1'b1;
         end

         if (clear) begin
            done    <= 1'b0;
            err     <= 1'b0;
            timeout <= 1'b0;
            overrun <= 1'b0;
         end

         if (reject) begin
            overrun <= 1'b1;
         end

         if (finish_ack) begin
            done <= 1'b1;
            err  <= bus_err;
            if (!bus_we && !bus_err) begin
               rdata <= bus_rdata;
            end
         end

         if (finish_to) begin
            done    <= 1'b1;
            timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_jtag_dbg_cmd_ctrl.sv
// tb_jtag_dbg_cmd_ctrl
// Self-checking bench: reset checks, a table of directed transactions with
// hand-derived status/rdata, hand-written sequences for overrun, ack/update
// collision, deselected update, stray acks and mid-transaction reset, then
// random commands checked against a transaction-level model.
module tb_jtag_dbg_cmd_ctrl;
   import jtag_dbg_pkg::*;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 15;
   localparam int SR1_W   = 2 + ADDR_W + DATA_W;
   localparam int SR2_W   = DATA_W + 5;

   logic              jtck = 1'b0;
   logic              jrstn = 1'b0;
   logic              jtdi = 1'b0;
   logic              jshift = 1'b0;
   logic              jupdate = 1'b0;
   logic              jce1 = 1'b0;
   logic              jce2 = 1'b0;
   logic              jtdo1;
   logic              jtdo2;
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_ack = 1'b0;
   logic              bus_err = 1'b0;
   logic [DATA_W-1:0] bus_rdata = '0;

   int checks = 0;
   int failures = 0;

   // Transaction-level reference state
   logic              m_done = 1'b0;
   logic              m_err = 1'b0;
   logic              m_timeout = 1'b0;
   logic              m_overrun = 1'b0;
   logic [DATA_W-1:0] m_rdata = '0;

   typedef struct {
      logic [1:0]        op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      int                delay;
      logic              err;
      logic [DATA_W-1:0] rdata;
      logic [4:0]        exp_status;
      logic [DATA_W-1:0] exp_rdata;
   } vec_t;

   vec_t vecs[8];

   always #5 jtck = ~jtck;

   jtag_dbg_cmd_ctrl #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .jtck      (jtck),
      .jrstn     (jrstn),
      .jtdi      (jtdi),
      .jshift    (jshift),
      .jupdate   (jupdate),
      .jce1      (jce1),
      .jce2      (jce2),
      .jtdo1     (jtdo1),
      .jtdo2     (jtdo2),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_err   (bus_err),
      .bus_rdata (bus_rdata)
   );

   task automatic tick();
      @(posedge jtck);
      #1;
   endtask

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [4:0] model_status();
      return {m_overrun, m_timeout, m_err, m_done, 1'b0};
   endfunction

   task automatic shift_er1(input logic [1:0] op, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      logic [SR1_W-1:0] v;
      v = {op, addr, data};
      jce1 = 1'b1;
      jshift = 1'b0;
      tick();
      jshift = 1'b1;
      for (int i = 0; i < SR1_W; i++) begin
         jtdi = v[i];
         tick();
      end
      jce1 = 1'b0;
      jshift = 1'b0;
      jtdi = 1'b0;
   endtask

   task automatic pulse_update();
      jupdate = 1'b1;
      tick();
      jupdate = 1'b0;
   endtask

   task automatic read_er2(output logic [SR2_W-1:0] v);
      jce2 = 1'b1;
      jshift = 1'b0;
      tick();
      jshift = 1'b1;
      for (int i = 0; i < SR2_W; i++) begin
         v[i] = jtdo2;
         tick();
      end
      jce2 = 1'b0;
      jshift = 1'b0;
   endtask

   task automatic check_er2(input string name, input logic [4:0] exp_status, input logic [DATA_W-1:0] exp_rdata);
      logic [SR2_W-1:0] v;
      read_er2(v);
      check_output({name, "_status"}, v[4:0], exp_status);
      check_output({name, "_rdata"}, v[SR2_W-1:5], exp_rdata);
   endtask

   // Issues one command through ER1 and, for WRITE/READ, acks it after
   // 'delay' request cycles (no ack at all when delay exceeds TIMEOUT)
   task automatic apply_stimulus(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] data, input int delay,
                                 input logic e, input logic [DATA_W-1:0] r);
      int cycles;
      int exp_cycles;
      shift_er1(op, addr, data);
      pulse_update();
      if (op == OP_WRITE || op == OP_READ) begin
         cycles = 0;
         for (int k = 0; k < 4 * (TIMEOUT + 1); k++) begin
            if (!bus_req) break;
            cycles++;
            check_output("bus_cmd", {bus_we, bus_addr, bus_wdata}, {op == OP_WRITE, addr, data});
            if (k == delay) begin
               bus_ack = 1'b1;
               bus_err = e;
               bus_rdata = r;
            end
            tick();
            bus_ack = 1'b0;
            bus_err = 1'b0;
            bus_rdata = $urandom;
         end
         exp_cycles = (delay <= TIMEOUT) ? delay + 1 : TIMEOUT + 1;
         check_output("req_cycles", 64'(cycles), 64'(exp_cycles));
         if (delay <= TIMEOUT) begin
            m_done = 1'b1;
            m_err = e;
            m_timeout = 1'b0;
            if (op == OP_READ && !e) m_rdata = r;
         end else begin
            m_done = 1'b1;
            m_err = 1'b0;
            m_timeout = 1'b1;
         end
      end else begin
         check_output("no_req", bus_req, 1'b0);
         tick();
         check_output("no_req_late", bus_req, 1'b0);
         if (op == OP_CLEAR) begin
            m_done = 1'b0;
            m_err = 1'b0;
            m_timeout = 1'b0;
            m_overrun = 1'b0;
         end
      end
   endtask

   initial begin
      logic [1:0]        r_op;
      logic [ADDR_W-1:0] r_addr;
      logic [DATA_W-1:0] r_data;
      logic [DATA_W-1:0] r_rdata;
      int                r_delay;
      logic              r_err;

      vecs[0] = '{OP_WRITE, 16'h0010, 32'hDEADBEEF, 3,  1'b0, 32'h0,        5'b00010, 32'h00000000};
      vecs[1] = '{OP_READ,  16'h0004, 32'h0,        2,  1'b0, 32'h12345678, 5'b00010, 32'h12345678};
      vecs[2] = '{OP_READ,  16'h0008, 32'h0,        1,  1'b1, 32'hFFFFFFFF, 5'b00110, 32'h12345678};
      vecs[3] = '{OP_WRITE, 16'h0020, 32'hCAFEF00D, 99, 1'b0, 32'h0,        5'b01010, 32'h12345678};
      vecs[4] = '{OP_READ,  16'h0030, 32'h0,        15, 1'b0, 32'hA5A55A5A, 5'b00010, 32'hA5A55A5A};
      vecs[5] = '{OP_WRITE, 16'h0040, 32'h01020304, 0,  1'b1, 32'h0,        5'b00110, 32'hA5A55A5A};
      vecs[6] = '{OP_NOP,   16'h0050, 32'h0,        0,  1'b0, 32'h0,        5'b00110, 32'hA5A55A5A};
      vecs[7] = '{OP_CLEAR, 16'h0000, 32'h0,        0,  1'b0, 32'h0,        5'b00000, 32'hA5A55A5A};

      jrstn = 1'b0;
      tick();
      tick();
      check_output("rst_req", bus_req, 1'b0);
      check_output("rst_we", bus_we, 1'b0);
      check_output("rst_addr", bus_addr, '0);
      check_output("rst_wdata", bus_wdata, '0);
      check_output("rst_tdo", {jtdo1, jtdo2}, 2'b00);
      jrstn = 1'b1;
      tick();
      check_er2("rst_er2", 5'b00000, 32'h0);

      for (int i = 0; i < 8; i++) begin
         apply_stimulus(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].delay, vecs[i].err, vecs[i].rdata);
         check_er2($sformatf("vec%0d", i), vecs[i].exp_status, vecs[i].exp_rdata);
      end

      // Second update while busy: dropped as overrun, first one completes
      shift_er1(OP_WRITE, 16'h0050, 32'h11112222);
      jupdate = 1'b1;
      tick();
      tick();
      jupdate = 1'b0;
      check_output("ovr_req", bus_req, 1'b1);
      check_output("ovr_addr", bus_addr, 16'h0050);
      tick();
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      check_output("ovr_req_drop", bus_req, 1'b0);
      tick();
      check_output("ovr_no_new_req", bus_req, 1'b0);
      check_er2("ovr", 5'b10010, 32'hA5A55A5A);
      apply_stimulus(OP_CLEAR, 16'h0, 32'h0, 0, 1'b0, 32'h0);
      check_er2("ovr_clear", 5'b00000, 32'hA5A55A5A);

      // Update coinciding with the ack still counts as an overrun
      shift_er1(OP_WRITE, 16'h0060, 32'h33334444);
      pulse_update();
      tick();
      jupdate = 1'b1;
      bus_ack = 1'b1;
      tick();
      jupdate = 1'b0;
      bus_ack = 1'b0;
      check_output("col_req_drop", bus_req, 1'b0);
      tick();
      check_output("col_no_new_req", bus_req, 1'b0);
      check_er2("col", 5'b10010, 32'hA5A55A5A);
      apply_stimulus(OP_CLEAR, 16'h0, 32'h0, 0, 1'b0, 32'h0);

      // Update with ER2 as last selected register is ignored
      shift_er1(OP_WRITE, 16'h0070, 32'h77778888);
      check_er2("desel_pre", 5'b00000, 32'hA5A55A5A);
      pulse_update();
      check_output("desel_req", bus_req, 1'b0);

      // Stray ack in IDLE changes nothing
      bus_ack = 1'b1;
      bus_err = 1'b1;
      bus_rdata = 32'hDEAD0000;
      tick();
      bus_ack = 1'b0;
      bus_err = 1'b0;
      tick();
      check_output("idle_ack_req", bus_req, 1'b0);
      check_er2("idle_ack", 5'b00000, 32'hA5A55A5A);

      for (int n = 0; n < 24; n++) begin
         r_op = 2'($urandom_range(0, 3));
         r_addr = 16'($urandom);
         r_data = $urandom;
         r_delay = int'($urandom_range(0, TIMEOUT + 3));
         r_err = ($urandom_range(0, 3) == 0);
         r_rdata = $urandom;
         apply_stimulus(r_op, r_addr, r_data, r_delay, r_err, r_rdata);
         check_er2($sformatf("rnd%0d", n), model_status(), m_rdata);
      end

      // Reset in the middle of a request
      shift_er1(OP_WRITE, 16'h0070, 32'h55556666);
      pulse_update();
      check_output("mid_rst_req_pre", bus_req, 1'b1);
      tick();
      #2 jrstn = 1'b0;
      #1;
      check_output("mid_rst_req_async", bus_req, 1'b0);
      check_output("mid_rst_bus", {bus_we, bus_addr, bus_wdata}, '0);
      check_output("mid_rst_tdo", {jtdo1, jtdo2}, 2'b00);
      tick();
      jrstn = 1'b1;
      tick();
      bus_ack = 1'b1;
      bus_rdata = 32'hBAD0BAD0;
      tick();
      bus_ack = 1'b0;
      check_output("late_ack_req", bus_req, 1'b0);
      check_er2("mid_rst", 5'b00000, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
